// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle control FSM for the ARM-subset processor
//
// Holds the decode context of the current instruction and keeps the NZCV flag
// register. It checks the condition field and steps the shared datapath
// through fetch, decode, execute, memory and writeback. Each cycle it drives
// one set of enables and mux selects.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-low reset
//   instr      - instruction register contents (cond/op/funct fields used)
//   flags_in   - NZCV from the registered ALU output
//   mem_ready  - memory accepted/completed the current request
//   mem_req    - memory access request
//   mem_write  - request is a store
//   adr_src    - memory address select (0 = PC, 1 = ALUOut)
//   ir_write   - instruction register load
//   pc_write   - PC load
//   reg_write  - register file write
//   result_src - result select (00 ALUOut, 01 read data, 10 ALU result)
//   alu_src_a  - ALU A select (0 = reg A, 1 = PC)
//   alu_src_b  - ALU B select (00 reg B, 01 ext imm, 10 const 4)
//   alu_ctrl   - ALU op (00 ADD, 01 SUB, 10 AND, 11 ORR)
//   imm_src    - immediate extension type (op field)
//   flags_out  - current NZCV register
//   state      - current state encoding (debug)
//   illegal    - one-cycle pulse on an undecodable instruction

module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  flags_in,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_ctrl,
  output logic [1:0]  imm_src,
  output logic [3:0]  flags_out,
  output logic [3:0]  state,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] flags_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       i_bit, s_bit, u_bit;
  logic [3:0] cmd;
  logic       unused_bits;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];   // S for data-processing, L for memory
  assign u_bit = funct[3];
  assign unused_bits = ^instr[19:0];

  // Standard ARM condition evaluation; f = {N, Z, C, V}.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_true = z;
      4'h1:    cond_true = !z;
      4'h2:    cond_true = cf;
      4'h3:    cond_true = !cf;
      4'h4:    cond_true = n;
      4'h5:    cond_true = !n;
      4'h6:    cond_true = v;
      4'h7:    cond_true = !v;
      4'h8:    cond_true = cf && !z;
      4'h9:    cond_true = !cf || z;
      4'hA:    cond_true = (n == v);
      4'hB:    cond_true = (n != v);
      4'hC:    cond_true = !z && (n == v);
      4'hD:    cond_true = z || (n != v);
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  logic       cmd_ok;
  logic       illegal_dec;
  logic       cond_ok;
  logic [1:0] cmd_alu;

  always_comb begin
    cmd_ok  = 1'b1;
    cmd_alu = 2'b00;
    case (cmd)
      CMD_AND: cmd_alu = 2'b10;
      CMD_SUB: cmd_alu = 2'b01;
      CMD_ADD: cmd_alu = 2'b00;
      CMD_CMP: cmd_alu = 2'b01;
      CMD_ORR: cmd_alu = 2'b11;
      default: cmd_ok  = 1'b0;
    endcase
  end

  // The cmd field is only meaningful for data-processing encodings.
  assign illegal_dec = (cond == 4'hF) || (op == 2'b11) || ((op == 2'b00) && !cmd_ok);
  assign cond_ok     = cond_true(cond, flags_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (state_q == ALUWB && (s_bit || cmd == CMD_CMP))
        flags_q <= flags_in;
    end
  end

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c;
  logic       reg_write_c, alu_src_a_c, illegal_c;
  logic [1:0] result_src_c, alu_src_b_c, alu_ctrl_c;

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    illegal_c    = 1'b0;
    result_src_c = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_ctrl_c   = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (illegal_dec) begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end else if (!cond_ok) begin
          state_d = FETCH;
        end else begin
          case (op)
            2'b01:   state_d = MEMADR;
            2'b00:   state_d = i_bit ? EXECI : EXECR;
            default: state_d = BRANCH;
          endcase
        end
      end
      MEMADR: begin
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = u_bit ? 2'b00 : 2'b01;
        state_d     = s_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        result_src_c = 2'b01;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_ctrl_c = cmd_alu;
        state_d    = ALUWB;
      end
      EXECI: begin
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = cmd_alu;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_c = (cmd != CMD_CMP);
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset overrides every enable and select combinationally.
  assign mem_req    = rst && mem_req_c;
  assign mem_write  = rst && mem_write_c;
  assign adr_src    = rst && adr_src_c;
  assign ir_write   = rst && ir_write_c;
  assign pc_write   = rst && pc_write_c;
  assign reg_write  = rst && reg_write_c;
  assign alu_src_a  = rst && alu_src_a_c;
  assign illegal    = rst && illegal_c;
  assign result_src = rst ? result_src_c : 2'b00;
  assign alu_src_b  = rst ? alu_src_b_c : 2'b00;
  assign alu_ctrl   = rst ? alu_ctrl_c : 2'b00;
  assign imm_src    = rst ? op : 2'b00;
  assign flags_out  = flags_q;
  assign state      = state_q;

endmodule
